// File: rtl/comparator_pkg.sv
// Shared definitions for the serial and parallel magnitude comparators:
// FSM state encoding and the one-hot {x,y,z} result encoding.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Map the final gt/lt decision flags onto the one-hot {x,y,z} result.
  function automatic logic [2:0] result_encode(input logic gt, input logic lt);
    logic [2:0] res;
    if (gt) begin
      res = RES_GT;
    end else if (lt) begin
      res = RES_LT;
    end else begin
      res = RES_EQ;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One MSB-first comparison step: the first differing bit pair sets gt or lt,
// after which the decision is held regardless of later bits.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic gt_in,
  input  logic lt_in,
  output logic gt_out,
  output logic lt_out
);

  logic undecided_s;

  assign undecided_s = ~gt_in & ~lt_in;
  assign gt_out      = gt_in | (undecided_s & a_bit & ~b_bit);
  assign lt_out      = lt_in | (undecided_s & ~a_bit & b_bit);

endmodule

// File: rtl/comparator_2bit_serial.sv
// Bit-serial magnitude comparator: accepts WIDTH bit pairs MSB first and
// reports A>B / A==B / A<B on x / y / z once the last beat is accepted.
module comparator_2bit_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic x,
  output logic y,
  output logic z
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             gt_r;
  logic             lt_r;
  logic             busy_r;
  logic             done_r;
  logic [2:0]       xyz_r;
  logic             gt_next_s;
  logic             lt_next_s;

  cmp_bit_cell u_cell (
    .a_bit (a_bit),
    .b_bit (b_bit),
    .gt_in (gt_r),
    .lt_in (lt_r),
    .gt_out(gt_next_s),
    .lt_out(lt_next_s)
  );

  // Control FSM, beat counter, decision flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO_CNT;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      xyz_r   <= RES_NONE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_SHIFT;
            cnt_r   <= ZERO_CNT;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            xyz_r   <= RES_NONE;
          end
        end
        ST_SHIFT: begin
          // start wins over a beat arriving in the same cycle
          if (start) begin
            cnt_r <= ZERO_CNT;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
          end else if (bit_valid) begin
            cnt_r <= cnt_r + ONE_CNT;
            gt_r  <= gt_next_s;
            lt_r  <= lt_next_s;
            if (cnt_r == LAST_CNT) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              xyz_r   <= result_encode(gt_next_s, lt_next_s);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= ZERO_CNT;
          gt_r    <= 1'b0;
          lt_r    <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          xyz_r   <= RES_NONE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign x    = xyz_r[2];
  assign y    = xyz_r[1];
  assign z    = xyz_r[0];

endmodule
